simon_datapath: RTL and testbench

- Datapath partner of the Simon controller FSM. It consumes the controller's strobes (cnt_count, clr_count, cnt_index, clr_index, w_en, read_Memory, set_level) and returns the status flags the FSM branches on (is_legal, index_lt_count, input_eq_pattern).
- Holds the pattern memory, the count and index counters, and the level register.
- Drives the pattern LEDs: memory playback or live switches, chosen by read_Memory.

---
 rtl/simon_pkg.sv | 7 +
 rtl/simon_pattern_mem.sv | 17 +
 rtl/simon_datapath.sv | 61 ++++++
 tb/tb_simon_datapath.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared sizing defaults and level encodings for the Simon game
package simon_pkg;
  localparam int SIMON_WIDTH = 4;
  localparam int SIMON_DEPTH = 64;
  localparam logic LEVEL_EASY = 1'b0;
  localparam logic LEVEL_HARD = 1'b1;
endpackage

// File: rtl/simon_pattern_mem.sv
// simon_pattern_mem: DEPTH x WIDTH pattern store with synchronous write and asynchronous read
module simon_pattern_mem #(
  parameter int WIDTH = simon_pkg::SIMON_WIDTH,
  parameter int DEPTH = simon_pkg::SIMON_DEPTH,
  localparam int LW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             w_en,
  input  logic [LW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [LW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (w_en) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/simon_datapath.sv
// simon_datapath: Simon pattern memory, count/index counters, level register and status flags
module simon_datapath
  import simon_pkg::*;
#(
  parameter int WIDTH = SIMON_WIDTH,
  parameter int DEPTH = SIMON_DEPTH,
  localparam int AW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             level,
  input  logic [WIDTH-1:0] pattern,
  input  logic             set_level,
  input  logic             cnt_count,
  input  logic             clr_count,
  input  logic             cnt_index,
  input  logic             clr_index,
  input  logic             w_en,
  input  logic             read_Memory,
  output logic             is_legal,
  output logic             index_lt_count,
  output logic             input_eq_pattern,
  output logic             mem_full,
  output logic [WIDTH-1:0] pattern_leds
);
  logic [AW-1:0] count_q, count_d, index_q, index_d;
  logic level_q, level_d, index_full, mem_we;
  logic [WIDTH-1:0] mem_rdata, rd_data;
  always_comb begin
    mem_full = count_q == AW'(DEPTH);
    index_full = index_q == AW'(DEPTH);
    count_d = clr_count ? '0 : (cnt_count && !mem_full) ? count_q + 1'b1 : count_q;
    index_d = clr_index ? '0 : (cnt_index && !index_full) ? index_q + 1'b1 : index_q;
    level_d = set_level ? level : level_q;
    mem_we = w_en && rst && !mem_full;
    rd_data = index_full ? '0 : mem_rdata;
    is_legal = level_q == LEVEL_HARD || $onehot(pattern);
    index_lt_count = index_q < count_q;
    input_eq_pattern = pattern == rd_data;
    pattern_leds = read_Memory ? rd_data : pattern;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      index_q <= '0;
      level_q <= level;
    end else begin
      count_q <= count_d;
      index_q <= index_d;
      level_q <= level_d;
    end
  end
  simon_pattern_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .w_en(mem_we),
    .waddr(count_q[AW-2:0]),
    .wdata(pattern),
    .raddr(index_q[AW-2:0]),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_simon_datapath.sv
// tb_simon_datapath: directed stimulus against a behavioural model of the Simon datapath
module tb_simon_datapath;
  logic clk = 0, rst = 0, level = 0, set_level = 0, cnt_count = 0, clr_count = 0;
  logic cnt_index = 0, clr_index = 0, w_en = 0, read_Memory = 0;
  logic [3:0] pattern = 0, pattern_leds;
  logic is_legal, index_lt_count, input_eq_pattern, mem_full;
  int total = 0, bad = 0;
  int m_count, m_index, m_level;
  logic [3:0] m_mem [64];
  bit m_known [64];
  bit started = 0;
  simon_datapath dut (
    .clk(clk), .rst(rst), .level(level), .pattern(pattern), .set_level(set_level),
    .cnt_count(cnt_count), .clr_count(clr_count), .cnt_index(cnt_index), .clr_index(clr_index),
    .w_en(w_en), .read_Memory(read_Memory), .is_legal(is_legal), .index_lt_count(index_lt_count),
    .input_eq_pattern(input_eq_pattern), .mem_full(mem_full), .pattern_leds(pattern_leds)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    if (!rst) begin
      m_count = 0;
      m_index = 0;
      m_level = int'(level);
    end else begin
      if (w_en && m_count < 64) begin
        m_mem[m_count] = pattern;
        m_known[m_count] = 1;
      end
      if (set_level) m_level = int'(level);
      if (clr_count) m_count = 0;
      else if (cnt_count && m_count < 64) m_count++;
      if (clr_index) m_index = 0;
      else if (cnt_index && m_index < 64) m_index++;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    started = 1;
    #1;
    {set_level, cnt_count, clr_count, cnt_index, clr_index, w_en} = '0;
  endtask
  always @(negedge clk) begin
    if (started) begin
      logic [3:0] rd;
      bit rd_ok;
      rd_ok = m_index == 64 || m_known[m_index];
      rd = m_index == 64 ? 4'd0 : m_mem[m_index];
      chk("model is_legal", {31'd0, is_legal}, (m_level == 1 || $countones(pattern) == 1) ? 1 : 0);
      chk("model index_lt_count", {31'd0, index_lt_count}, m_index < m_count ? 1 : 0);
      chk("model mem_full", {31'd0, mem_full}, m_count == 64 ? 1 : 0);
      if (rd_ok) chk("model input_eq_pattern", {31'd0, input_eq_pattern}, pattern == rd ? 1 : 0);
      if (rd_ok || !read_Memory) chk("model pattern_leds", {28'd0, pattern_leds}, {28'd0, read_Memory ? rd : pattern});
    end
  end
  initial begin
    for (int i = 0; i < 64; i++) m_known[i] = 0;
    cyc();
    rst = 1;
    pattern = 4'b0100;
    @(negedge clk);
    chk("reset lt", {31'd0, index_lt_count}, 0);
    chk("reset full", {31'd0, mem_full}, 0);
    chk("easy onehot", {31'd0, is_legal}, 1);
    pattern = 4'b0110;
    @(negedge clk) chk("easy twobit", {31'd0, is_legal}, 0);
    pattern = 4'b0000;
    @(negedge clk) chk("easy zero", {31'd0, is_legal}, 0);
    set_level = 1; level = 1;
    cyc();
    pattern = 4'b0110;
    @(negedge clk) chk("hard twobit", {31'd0, is_legal}, 1);
    set_level = 1; level = 0;
    cyc();
    level = 1;
    @(negedge clk) chk("level held", {31'd0, is_legal}, 0);
    w_en = 1; pattern = 4'b0001; cyc();
    cnt_count = 1; cyc();
    w_en = 1; pattern = 4'b1000; cyc();
    cnt_count = 1; cyc();
    clr_index = 1; cyc();
    @(negedge clk) chk("lt after writes", {31'd0, index_lt_count}, 1);
    read_Memory = 1;
    @(negedge clk) chk("play mem0", {28'd0, pattern_leds}, 4'b0001);
    cnt_index = 1; cyc();
    @(negedge clk) chk("play mem1", {28'd0, pattern_leds}, 4'b1000);
    cnt_index = 1; cyc();
    @(negedge clk) chk("lt index2", {31'd0, index_lt_count}, 0);
    clr_index = 1; cyc();
    cnt_index = 1; cyc();
    read_Memory = 0; pattern = 4'b1000;
    @(negedge clk);
    chk("eq match", {31'd0, input_eq_pattern}, 1);
    chk("leds live 1000", {28'd0, pattern_leds}, 4'b1000);
    pattern = 4'b0001;
    @(negedge clk);
    chk("eq miss", {31'd0, input_eq_pattern}, 0);
    chk("leds live 0001", {28'd0, pattern_leds}, 4'b0001);
    clr_index = 1; cnt_index = 1; cyc();
    read_Memory = 1;
    @(negedge clk) chk("clr_index wins", {28'd0, pattern_leds}, 4'b0001);
    clr_count = 1; cnt_count = 1; cyc();
    @(negedge clk) chk("clr_count wins", {31'd0, index_lt_count}, 0);
    rst = 0; w_en = 1; pattern = 4'b0111; cyc();
    rst = 1;
    @(negedge clk) chk("reset blocks write", {28'd0, pattern_leds}, 4'b0001);
    for (int i = 0; i < 63; i++) begin
      cnt_count = 1; cyc();
    end
    @(negedge clk) chk("full at 63", {31'd0, mem_full}, 0);
    cnt_count = 1; cyc();
    @(negedge clk) chk("full at 64", {31'd0, mem_full}, 1);
    w_en = 1; pattern = 4'b0010; cyc();
    @(negedge clk) chk("full write dropped", {28'd0, pattern_leds}, 4'b0001);
    cnt_count = 1; cyc();
    @(negedge clk) chk("count saturates", {31'd0, mem_full}, 1);
    for (int i = 0; i < 66; i++) begin
      cnt_index = 1; cyc();
    end
    pattern = 4'b0000;
    @(negedge clk);
    chk("index64 leds", {28'd0, pattern_leds}, 4'b0000);
    chk("index64 lt", {31'd0, index_lt_count}, 0);
    chk("index64 eq", {31'd0, input_eq_pattern}, 1);
    rst = 0; level = 1; cyc();
    rst = 1; level = 0; pattern = 4'b0110;
    @(negedge clk);
    chk("reset clears full", {31'd0, mem_full}, 0);
    chk("reset loads level", {31'd0, is_legal}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
